pipe_scheduler: RTL and testbench
=================================

Name: pipe_scheduler

Overview:
Frame-level sequencer for the scrolling pipes, directly upstream of the per-pipe outline drawer. Holds NUM_PIPES pipe anchors (column, gap row) and scrolls them left by SPEED once per frame_tick while run is high. Respawns off-screen pipes with an LFSR-derived gap row. Hands each pipe to the drawer in turn over an enable/done handshake.

Parameters:
NUM_PIPES, 3, number of pipes in flight (index width = $clog2(NUM_PIPES))
SPEED, 2, pixels moved left per frame
SPACING, 220, column distance between consecutive pipes
X_START, 700, reset column of pipe 0; pipe i = X_START + i*SPACING
Y_INIT, 240, reset gap row of every pipe
Y_MIN, 180, respawn gap row = Y_MIN + lfsr[6:0] (range 180..307)
BIRD_X, 100, scoring column (optional feature only)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
frame_tick  in  1  one-cycle pulse per frame (vblank start)
run  in  1  1 = scroll on frame; 0 = redraw in place
draw_en  out  1  enable to drawer; held until draw_done
draw_x  out  11  pipe anchor column to drawer, stable while draw_en=1
draw_y  out  11  pipe gap anchor row to drawer, stable while draw_en=1
draw_done  in  1  one-cycle pulse from drawer: outline finished
busy  out  1  high from accepted frame_tick until frame_done
frame_done  out  1  one-cycle pulse after last pipe drawn
score  out  10  pipes passed (optional feature; else constant 0)

Behaviour:
- Reset (async, any state): state=S_IDLE; pipe i x=X_START+i*SPACING, y=Y_INIT; lfsr=8'hA5; draw_en, draw_x, draw_y, busy, frame_done, score = 0. All outputs registered.
- States: S_IDLE, S_MOVE, S_SETUP, S_DRAW, S_DONE; idx counter 0..NUM_PIPES-1.
- S_IDLE: frame_tick=1 -> S_MOVE if run else S_SETUP; idx<=0; busy<=1. frame_tick while not S_IDLE ignored (no queueing).
- S_MOVE: one cycle per pipe idx. If x[idx] <= SPEED: x <= x - SPEED + NUM_PIPES*SPACING, lfsr advances once, y <= Y_MIN + new lfsr[6:0]. Else x <= x - SPEED. idx wraps to 0 after last pipe -> S_SETUP.
- S_SETUP: draw_x<=x[idx], draw_y<=y[idx], draw_en<=0; -> S_DRAW next cycle with draw_en<=1. Guarantees draw_en low at least 1 cycle between pipes so the drawer returns to idle.
- S_DRAW: hold draw_en, draw_x, draw_y. On draw_done: draw_en<=0 on that same edge; if idx==NUM_PIPES-1 -> S_DONE else idx++ -> S_SETUP.
- S_DONE: frame_done=1 for exactly one cycle, busy<=0 -> S_IDLE.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1: next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}; advances only on respawn; never reaches 0.
- Arithmetic 11-bit unsigned; wrap test precedes subtraction so x never underflows. Spacing between pipes is invariant.
- Frame latency = 1 + NUM_PIPES (move, if run) + sum over pipes of (1 setup + drawer time) + 1 done.
- draw_done outside S_DRAW ignored. run sampled only at frame_tick acceptance.

Optional Feature:
PIPE_SCORE_EN defined: in S_MOVE, if old x >= BIRD_X and new x < BIRD_X (non-respawn path), score increments, saturating at 999; async reset clears it. Undefined: no score register; score tied to 0.

Decomposition:
- Package pipe_pkg: typedef coord_t (logic [10:0]); state enum; SCREEN constants; LFSR seed 8'hA5 and tap mask.
- Sub-module pipe_lfsr8 (clk, reset, step, value[7:0]) holds the LFSR; everything else stays in pipe_scheduler.

Test Plan:
- Reset mid-S_DRAW -> draw_en, busy drop immediately (async); pipe x = 700/920/1140, y = 240.
- run=1, frame_tick, drawer model returns done 5 cycles after enable -> draw (698,240), (918,240), (1138,240) in order; draw_en low >=1 cycle between pipes; one frame_done; busy high throughout.
- run=0, frame_tick -> draws 700/920/1140 unchanged; no S_MOVE cycles; lfsr unchanged.
- 349 run frames -> pipe0 x=2; frame 350 -> pipe0 x=660, y=254 (lfsr 0xA5->0x4A); pipe1 x=220, pipe2 x=440.
- frame_tick pulsed during S_DRAW -> ignored; exactly one frame_done; positions moved once.
- PIPE_SCORE_EN, BIRD_X=100: frame 300 -> pipe0 x=100, score 0; frame 301 -> x=98, score=1; macro undefined -> score stays 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipe scheduler: coordinate type, FSM states,
// screen geometry and the 8-bit gap-row LFSR (seed, taps, step function).
package pipe_pkg;

  typedef logic [10:0] coord_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MOVE  = 3'd1,
    S_SETUP = 3'd2,
    S_DRAW  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Taps x^8+x^6+x^5+x^4+1 map to state bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/pipe_lfsr8.sv
// 8-bit Fibonacci LFSR supplying respawn gap rows; advances only when step is high.
module pipe_lfsr8
  import pipe_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       step,
  output logic [7:0] value
);

  logic [7:0] r_value;

  // LFSR state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_value <= LFSR_SEED;
    end else if (step) begin
      r_value <= lfsr_next(r_value);
    end else begin
      r_value <= r_value;
    end
  end

  assign value = r_value;

endmodule

// File: rtl/pipe_scheduler.sv
// Frame sequencer: scrolls NUM_PIPES pipe anchors, respawns them, and feeds each to the drawer.
// Optional scoring against BIRD_X is enabled by defining PIPE_SCORE_EN.
module pipe_scheduler
  import pipe_pkg::*;
#(
  parameter int NUM_PIPES = 3,
  parameter int SPEED     = 2,
  parameter int SPACING   = 220,
  parameter int X_START   = 700,
  parameter int Y_INIT    = 240,
  parameter int Y_MIN     = 180
`ifdef PIPE_SCORE_EN
  , parameter int BIRD_X  = 100
`endif
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        run,
  output logic        draw_en,
  output logic [10:0] draw_x,
  output logic [10:0] draw_y,
  input  logic        draw_done,
  output logic        busy,
  output logic        frame_done,
  output logic [9:0]  score
);

  localparam int IDX_W = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_idx;
  coord_t             r_x [NUM_PIPES];
  coord_t             r_y [NUM_PIPES];
  logic               r_draw_en;
  coord_t             r_draw_x;
  coord_t             r_draw_y;
  logic               r_busy;
  logic               r_frame_done;

  logic               w_last;
  coord_t             w_x_cur;
  logic               w_wrap;
  coord_t             w_x_new;
  coord_t             w_y_new;
  logic               w_lfsr_step;
  logic [7:0]         w_lfsr_val;
  logic [7:0]         w_lfsr_new;

  pipe_lfsr8 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .step  (w_lfsr_step),
    .value (w_lfsr_val)
  );

  // Wrap test comes before subtraction so the column never underflows
  always_comb begin
    w_last      = (r_idx == IDX_W'(NUM_PIPES - 1));
    w_x_cur     = r_x[r_idx];
    w_wrap      = (w_x_cur <= 11'(SPEED));
    w_lfsr_step = (r_state == S_MOVE) && w_wrap;
    w_lfsr_new  = lfsr_next(w_lfsr_val);
    w_y_new     = 11'(Y_MIN) + {3'd0, (w_lfsr_new & 8'h7F)};
    if (w_wrap) begin
      w_x_new = w_x_cur - 11'(SPEED) + 11'(NUM_PIPES * SPACING);
    end else begin
      w_x_new = w_x_cur - 11'(SPEED);
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (frame_tick) begin
          w_state_nxt = run ? S_MOVE : S_SETUP;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_MOVE: begin
        if (w_last) begin
          w_state_nxt = S_SETUP;
        end else begin
          w_state_nxt = S_MOVE;
        end
      end
      S_SETUP: w_state_nxt = S_DRAW;
      S_DRAW: begin
        if (draw_done) begin
          w_state_nxt = w_last ? S_DONE : S_SETUP;
        end else begin
          w_state_nxt = S_DRAW;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Pipe anchors, index counter and registered drawer-side outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PIPES; i++) begin
        r_x[i] <= 11'(X_START + i * SPACING);
        r_y[i] <= 11'(Y_INIT);
      end
      r_idx        <= '0;
      r_draw_en    <= 1'b0;
      r_draw_x     <= 11'd0;
      r_draw_y     <= 11'd0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (frame_tick) begin
            r_idx  <= '0;
            r_busy <= 1'b1;
          end
        end
        S_MOVE: begin
          r_x[r_idx] <= w_x_new;
          if (w_wrap) begin
            r_y[r_idx] <= w_y_new;
          end
          r_idx <= w_last ? '0 : r_idx + 1'b1;
        end
        S_SETUP: begin
          r_draw_x  <= r_x[r_idx];
          r_draw_y  <= r_y[r_idx];
          r_draw_en <= 1'b1;
        end
        S_DRAW: begin
          if (draw_done) begin
            r_draw_en <= 1'b0;
            if (w_last) begin
              r_frame_done <= 1'b1;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        S_DONE: begin
          r_busy <= 1'b0;
        end
        default: begin
          r_draw_en <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

`ifdef PIPE_SCORE_EN
  logic [9:0] r_score;

  // Count pipes whose column crosses the bird on a normal (non-respawn) move
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_score <= 10'd0;
    end else if ((r_state == S_MOVE) && !w_wrap && (w_x_cur >= 11'(BIRD_X)) &&
                 (w_x_new < 11'(BIRD_X)) && (r_score != 10'd999)) begin
      r_score <= r_score + 10'd1;
    end else begin
      r_score <= r_score;
    end
  end

  assign score = r_score;
`else
  assign score = 10'd0;
`endif

  assign draw_en    = r_draw_en;
  assign draw_x     = r_draw_x;
  assign draw_y     = r_draw_y;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_pipe_scheduler.sv
// Randomized scoreboard bench for pipe_scheduler with a random-latency drawer model.
module tb_pipe_scheduler;

  localparam int NUM     = 3;
  localparam int SPEED   = 2;
  localparam int SPACING = 220;
  localparam int X_START = 700;
  localparam int Y_INIT  = 240;
  localparam int Y_MIN   = 180;
  localparam int BIRD_X  = 100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic        run = 1'b0;
  logic        draw_en;
  logic [10:0] draw_x;
  logic [10:0] draw_y;
  logic        draw_done = 1'b0;
  logic        busy;
  logic        frame_done;
  logic [9:0]  score;

  pipe_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .run        (run),
    .draw_en    (draw_en),
    .draw_x     (draw_x),
    .draw_y     (draw_y),
    .draw_done  (draw_done),
    .busy       (busy),
    .frame_done (frame_done),
    .score      (score)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model state
  int         mx [NUM];
  int         my [NUM];
  logic [7:0] ml;
  int         msc;

  int exp_x[$];
  int exp_y[$];
  int exp_sc[$];
  int frames_exp = 0;
  int frames_seen = 0;

  int first_x = -1;
  int first_y = -1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM; i++) begin
      mx[i] = X_START + i * SPACING;
      my[i] = Y_INIT;
    end
    ml  = 8'hA5;
    msc = 0;
    exp_x.delete();
    exp_y.delete();
    exp_sc.delete();
    frames_exp  = 0;
    frames_seen = 0;
  endtask

  task automatic model_frame(input bit run_v);
    int old;
    if (run_v) begin
      for (int i = 0; i < NUM; i++) begin
        if (mx[i] <= SPEED) begin
          mx[i] = mx[i] - SPEED + NUM * SPACING;
          ml    = {ml[6:0], ml[7] ^ ml[5] ^ ml[4] ^ ml[3]};
          my[i] = Y_MIN + int'(ml[6:0]);
        end else begin
          old   = mx[i];
          mx[i] = mx[i] - SPEED;
`ifdef PIPE_SCORE_EN
          if (old >= BIRD_X && mx[i] < BIRD_X && msc < 999) msc++;
`else
          if (old < 0) msc = -1;
`endif
        end
      end
    end
    for (int i = 0; i < NUM; i++) begin
      exp_x.push_back(mx[i]);
      exp_y.push_back(my[i]);
    end
    exp_sc.push_back(msc);
    frames_exp++;
  endtask

  // Drawer model: done pulse after a random number of enabled cycles, plus stray pulses while idle
  int lat = 5;
  int cnt = 0;
  always begin
    @(posedge clk);
    #1;
    if (reset) begin
      draw_done = 1'b0;
      cnt = 0;
    end else if (draw_done) begin
      draw_done = 1'b0;
    end else if (draw_en) begin
      cnt++;
      if (cnt >= lat) begin
        draw_done = 1'b1;
        cnt = 0;
        lat = $urandom_range(1, 6);
      end
    end else if ($urandom_range(0, 7) == 0) begin
      draw_done = 1'b1;
    end
  end

  // Monitor: compares each presented draw and frame completion against the scoreboard
  logic prev_en = 1'b0;
  int   cur_x, cur_y, in_frame = 0;
  always @(negedge clk) begin
    if (reset) begin
      prev_en  = 1'b0;
      in_frame = 0;
    end else begin
      if (draw_en && !prev_en) begin
        if (exp_x.size() == 0) begin
          chk("unexpected_draw", 1, 0);
        end else begin
          chk("draw_x", int'(draw_x), exp_x.pop_front());
          chk("draw_y", int'(draw_y), exp_y.pop_front());
        end
        cur_x = int'(draw_x);
        cur_y = int'(draw_y);
        if (in_frame == 0) begin
          first_x = cur_x;
          first_y = cur_y;
        end
        in_frame++;
      end else if (draw_en) begin
        chk("draw_x_stable", int'(draw_x), cur_x);
        chk("draw_y_stable", int'(draw_y), cur_y);
      end
      if (draw_en) chk("busy_during_draw", int'(busy), 1);
      if (frame_done) begin
        chk("draws_per_frame", in_frame, NUM);
        chk("busy_at_done", int'(busy), 1);
        chk("draw_en_at_done", int'(draw_en), 0);
        if (exp_sc.size() == 0) chk("unexpected_frame_done", 1, 0);
        else chk("score", int'(score), exp_sc.pop_front());
        frames_seen++;
        in_frame = 0;
      end
      prev_en = draw_en;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 5000) chk("idle_timeout", 1, 0);
  endtask

  task automatic frame(input bit run_v, input bit inject);
    int n = 0;
    wait_idle();
    frame_tick = 1'b1;
    run = run_v;
    model_frame(run_v);
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    run = 1'($urandom);
    while (busy && n < 5000) begin
      frame_tick = inject && ($urandom_range(0, 15) == 0);
      @(posedge clk);
      #1;
      n++;
    end
    frame_tick = 1'b0;
    if (n >= 5000) chk("frame_timeout", 1, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_draw_en"}, int'(draw_en), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_frame_done"}, int'(frame_done), 0);
    chk({tag, "_draw_x"}, int'(draw_x), 0);
    chk({tag, "_score"}, int'(score), 0);
  endtask

  initial begin
    int n;
    model_reset();
    #2;
    check_reset_outputs("reset0");
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    frame(1'b1, 1'b0);
    frame(1'b0, 1'b0);
    frame(1'b1, 1'b1);

    // reset while a pipe is being drawn
    wait_idle();
    frame_tick = 1'b1;
    run = 1'b1;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    n = 0;
    while (!draw_en && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("draw_en_before_reset", int'(draw_en), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_draw_en", int'(draw_en), 0);
    chk("async_busy", int'(busy), 0);
    model_reset();
    @(posedge clk);
    #1;
    check_reset_outputs("reset1");
    reset = 1'b0;

    // first post-reset frame is a redraw in place: 700/920/1140 at row 240
    frame(1'b0, 1'b0);
    chk("redraw_first_x", first_x, X_START);
    chk("redraw_first_y", first_y, Y_INIT);

    for (int f = 1; f <= 350; f++) begin
      frame(1'b1, f[3]);
      if (f == 349) chk("frame349_pipe0_x", first_x, 2);
    end
    chk("frame350_pipe0_x", first_x, 660);
    chk("frame350_pipe0_y", first_y, 254);

    for (int f = 0; f < 40; f++) begin
      frame(1'($urandom_range(0, 3) != 0), 1'b1);
    end

    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("frames_completed", frames_seen, frames_exp);
    chk("draws_left", exp_x.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
